// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: SFR-bus sequencer in front of the SPI master. It turns a
// host byte stream into a programmed burst of SPI transfers: one SPCR write
// per burst, then for each byte an SPDR write, SPIF polling, an SPDR read, an
// SPIF clear and a handshake on the rx stream.
//
// Ports:
//   CLK, RESETn            clock, asynchronous active-low reset
//   start/cfg_spcr/len     burst request (len 0 = 256 bytes)
//   busy/done/err          burst status (err is a sticky SPIF timeout)
//   tx_data/valid/ready    host -> SPI byte stream
//   rx_data/valid/ready    SPI -> host byte stream
//   psel/penable/WE/RE     SFR access strobes (penable is active low)
//   ADDRD/DATABO/DATABI    SFR address, write data, read data
module spi_burst_ctrl #(
  parameter logic [7:0]  SPCR_ADDR      = 8'h02,
  parameter logic [7:0]  SPSR_ADDR      = 8'h03,
  parameter logic [7:0]  SPDR_ADDR      = 8'h04,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       start,
  input  logic [7:0] cfg_spcr,
  input  logic [7:0] len,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       psel,
  output logic       penable,
  output logic       WE,
  output logic       RE,
  output logic [7:0] ADDRD,
  output logic [7:0] DATABO,
  input  logic [7:0] DATABI
);

  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 9;
  localparam int unsigned TO_W  = 12;

  localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(256);
  localparam logic [DW-1:0]    SPE_BIT   = 8'h40;
  localparam logic [DW-1:0]    SPIF_CLR  = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SPCR,
    S_GET_TX,
    S_WR_SPDR,
    S_POLL,
    S_RD_SPDR,
    S_CLR_SPIF,
    S_PUSH_RX
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DW-1:0]     r_cfg,      w_cfg_nxt;
  logic [CNT_W-1:0]  r_remain,   w_remain_nxt;
  logic [TO_W-1:0]   r_timeout,  w_timeout_nxt;
  logic [DW-1:0]     r_tx_byte,  w_tx_byte_nxt;
  logic [DW-1:0]     r_rx_data,  w_rx_data_nxt;
  logic              r_err,      w_err_nxt;
  logic              r_done,     w_done_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_tx_ready, w_tx_ready_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              r_psel,     w_psel_nxt;
  logic              r_penable,  w_penable_nxt;
  logic              r_we,       w_we_nxt;
  logic              r_re,       w_re_nxt;
  logic [DW-1:0]     r_addr,     w_addr_nxt;
  logic [DW-1:0]     r_dout,     w_dout_nxt;

  // State and all registered outputs
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= S_IDLE;
      r_cfg      <= '0;
      r_remain   <= '0;
      r_timeout  <= '0;
      r_tx_byte  <= '0;
      r_rx_data  <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_ready <= 1'b0;
      r_rx_valid <= 1'b0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b1;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_addr     <= '0;
      r_dout     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cfg      <= w_cfg_nxt;
      r_remain   <= w_remain_nxt;
      r_timeout  <= w_timeout_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_err      <= w_err_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_psel     <= w_psel_nxt;
      r_penable  <= w_penable_nxt;
      r_we       <= w_we_nxt;
      r_re       <= w_re_nxt;
      r_addr     <= w_addr_nxt;
      r_dout     <= w_dout_nxt;
    end
  end

  // Next state, datapath updates, and output decode of the next state so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    w_state_nxt    = r_state;
    w_cfg_nxt      = r_cfg;
    w_remain_nxt   = r_remain;
    w_timeout_nxt  = r_timeout;
    w_tx_byte_nxt  = r_tx_byte;
    w_rx_data_nxt  = r_rx_data;
    w_err_nxt      = r_err;
    w_done_nxt     = 1'b0;
    w_psel_nxt     = 1'b0;
    w_penable_nxt  = 1'b1;
    w_we_nxt       = 1'b0;
    w_re_nxt       = 1'b0;
    w_addr_nxt     = '0;
    w_dout_nxt     = '0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cfg_nxt    = cfg_spcr;
          w_remain_nxt = (len == '0) ? CNT_FULL : CNT_W'(len);
          w_err_nxt    = 1'b0;
          w_state_nxt  = S_WR_SPCR;
        end
      end
      S_WR_SPCR: w_state_nxt = S_GET_TX;
      S_GET_TX: begin
        if (tx_valid && r_tx_ready) begin
          w_tx_byte_nxt = tx_data;
          w_state_nxt   = S_WR_SPDR;
        end
      end
      S_WR_SPDR: begin
        w_timeout_nxt = TO_LOAD;
        w_state_nxt   = S_POLL;
      end
      S_POLL: begin
        // DATABI reflects SPSR for the read issued in this cycle
        if (DATABI[0]) begin
          w_state_nxt = S_RD_SPDR;
        end else if (r_timeout == '0) begin
          w_err_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_timeout_nxt = r_timeout - TO_W'(1);
        end
      end
      S_RD_SPDR: begin
        w_rx_data_nxt = DATABI;
        w_state_nxt   = S_CLR_SPIF;
      end
      S_CLR_SPIF: w_state_nxt = S_PUSH_RX;
      S_PUSH_RX: begin
        if (rx_ready) begin
          w_remain_nxt = r_remain - CNT_ONE;
          if (r_remain == CNT_ONE) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_GET_TX;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_tx_ready_nxt = (w_state_nxt == S_GET_TX);
    w_rx_valid_nxt = (w_state_nxt == S_PUSH_RX);

    // SFR access for the cycle the FSM is about to enter
    case (w_state_nxt)
      S_WR_SPCR: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b0;
        w_we_nxt      = 1'b1;
        w_addr_nxt    = SPCR_ADDR;
        w_dout_nxt    = w_cfg_nxt | SPE_BIT;
      end
      S_WR_SPDR: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b0;
        w_we_nxt      = 1'b1;
        w_addr_nxt    = SPDR_ADDR;
        w_dout_nxt    = w_tx_byte_nxt;
      end
      S_POLL: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b0;
        w_re_nxt      = 1'b1;
        w_addr_nxt    = SPSR_ADDR;
      end
      S_RD_SPDR: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b0;
        w_re_nxt      = 1'b1;
        w_addr_nxt    = SPDR_ADDR;
      end
      S_CLR_SPIF: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b0;
        w_we_nxt      = 1'b1;
        w_addr_nxt    = SPSR_ADDR;
        w_dout_nxt    = SPIF_CLR;
      end
      default: ;
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign psel     = r_psel;
  assign penable  = r_penable;
  assign WE       = r_we;
  assign RE       = r_re;
  assign ADDRD    = r_addr;
  assign DATABO   = r_dout;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a small SFR-level SPI master model.
module tb_spi_burst_ctrl;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       start;
  logic [7:0] cfg_spcr;
  logic [7:0] len;
  logic       busy, done, err;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       psel, penable, WE, RE;
  logic [7:0] ADDRD, DATABO, DATABI;

  always #5 CLK = ~CLK;

  spi_burst_ctrl #(.TIMEOUT_CYCLES(16)) u_dut (
    .CLK(CLK), .RESETn(RESETn), .start(start), .cfg_spcr(cfg_spcr), .len(len),
    .busy(busy), .done(done), .err(err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .psel(psel), .penable(penable), .WE(WE), .RE(RE),
    .ADDRD(ADDRD), .DATABO(DATABO), .DATABI(DATABI)
  );

  // SPI master model: SPIF sets 8 cycles after an SPDR write unless stuck;
  // received byte is the written byte, optionally inverted.
  bit         sl_stuck;
  bit         sl_invert;
  logic       sl_spif;
  logic [7:0] sl_rx;
  int         sl_cnt;

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sl_spif <= 1'b0;
      sl_rx   <= 8'h00;
      sl_cnt  <= 0;
    end else begin
      if (psel && !penable && WE && ADDRD == 8'h04) begin
        sl_rx  <= sl_invert ? ~DATABO : DATABO;
        sl_cnt <= 8;
      end else if (sl_cnt > 0) begin
        sl_cnt <= sl_cnt - 1;
        if (sl_cnt == 1 && !sl_stuck) sl_spif <= 1'b1;
      end
      if (psel && !penable && WE && ADDRD == 8'h03 && DATABO[0]) sl_spif <= 1'b0;
    end
  end

  assign DATABI = (ADDRD == 8'h03) ? {7'b0, sl_spif} :
                  (ADDRD == 8'h04) ? sl_rx : 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [7:0]  tx_mem [256];
  logic [7:0]  rx_q [$];
  logic [15:0] wr_log [$];
  int n_spsr_rd, n_spdr_wr, n_spsr_clr, n_done, busy_gap, n_ovl;
  int stall_acc, stall_ready, stall_hold, rx_unstable;
  bit done_seen;
  logic err_at_done, err_first;

  function automatic logic [15:0] wr_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 16'hDEAD;
  endfunction

  function automatic logic [7:0] rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hXX;
  endfunction

  // One burst; the bench reacts on the falling edge so handshakes land on the
  // next rising edge. gap_idx/hold_idx < 0 disables the stall.
  task automatic run_burst(input int n, input logic [7:0] cfg,
                           input int gap_idx, input int gap_len,
                           input int hold_idx, input int hold_len);
    int tx_idx = 0;
    int rx_idx = 0;
    int gap_left = gap_len;
    int hold_left = hold_len;
    logic [7:0] held = 8'h00;
    rx_q.delete();
    wr_log.delete();
    n_spsr_rd = 0; n_spdr_wr = 0; n_spsr_clr = 0; n_done = 0; busy_gap = 0; n_ovl = 0;
    stall_acc = 0; stall_ready = 0; stall_hold = 0; rx_unstable = 0;
    done_seen = 1'b0; err_at_done = 1'b0;
    @(negedge CLK);
    start = 1'b1; cfg_spcr = cfg; len = 8'(n);
    @(negedge CLK);
    start = 1'b0;
    err_first = err;
    for (int c = 0; c < 8000 && !done_seen; c++) begin
      if (c > 0) @(negedge CLK);
      if (done) begin
        n_done++;
        done_seen = 1'b1;
        err_at_done = err;
        if (busy) n_ovl++;
      end else if (!busy) begin
        busy_gap++;
      end
      if (tx_ready && rx_valid) n_ovl++;
      if (psel && !penable && WE) begin
        wr_log.push_back({ADDRD, DATABO});
        if (ADDRD == 8'h04) n_spdr_wr++;
        if (ADDRD == 8'h03) n_spsr_clr++;
      end
      if (psel && !penable && RE && ADDRD == 8'h03) n_spsr_rd++;
      rx_ready = 1'b0;
      if (rx_valid) begin
        if (rx_idx == hold_idx && hold_left > 0) begin
          if (hold_left == hold_len) held = rx_data;
          else if (rx_data !== held) rx_unstable++;
          hold_left--;
          stall_hold++;
          if (psel) stall_acc++;
        end else begin
          rx_ready = 1'b1;
          rx_q.push_back(rx_data);
          rx_idx++;
        end
      end
      tx_valid = 1'b0;
      if (tx_ready) begin
        if (tx_idx == gap_idx && gap_left > 0) begin
          gap_left--;
          stall_ready++;
          if (psel) stall_acc++;
        end else begin
          tx_valid = 1'b1;
          tx_data  = tx_mem[tx_idx];
          tx_idx++;
        end
      end
    end
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    check("burst_done_seen", 32'(done_seen), 1);
  endtask

  initial begin
    RESETn = 1'b0; start = 1'b0; cfg_spcr = 8'h00; len = 8'h00;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    sl_stuck = 1'b0; sl_invert = 1'b0;
    for (int i = 0; i < 256; i++) tx_mem[i] = 8'(i);
    repeat (3) @(negedge CLK);
    check("reset_ctrl", {busy, done, err, tx_ready, rx_valid, psel, penable, WE, RE}, 9'b000000100);
    check("reset_bus", {ADDRD, DATABO, rx_data}, 24'h000000);
    RESETn = 1'b1;

    // Single byte, loopback
    tx_mem[0] = 8'hA5;
    run_burst(1, 8'h53, -1, 0, -1, 0);
    check("t1_nwr", wr_log.size(), 3);
    check("t1_wr0", wr_at(0), 16'h0253);
    check("t1_wr1", wr_at(1), 16'h04A5);
    check("t1_wr2", wr_at(2), 16'h0301);
    check("t1_rx", rx_at(0), 8'hA5);
    check("t1_done", n_done, 1);
    check("t1_err", err_at_done, 0);
    check("t1_busy", busy_gap, 0);

    // Four bytes, inverting slave, SPE forced into SPCR
    sl_invert = 1'b1;
    for (int i = 0; i < 4; i++) tx_mem[i] = 8'(i + 1);
    run_burst(4, 8'h10, -1, 0, -1, 0);
    check("t2_spcr", wr_at(0), 16'h0250);
    check("t2_rx0", rx_at(0), 8'hFE);
    check("t2_rx1", rx_at(1), 8'hFD);
    check("t2_rx2", rx_at(2), 8'hFC);
    check("t2_rx3", rx_at(3), 8'hFB);
    check("t2_nspdr", n_spdr_wr, 4);
    check("t2_nclr", n_spsr_clr, 4);
    check("t2_busy", busy_gap, 0);
    check("t2_ovl", n_ovl, 0);

    // len=0 -> 256 bytes, loopback of incrementing data
    sl_invert = 1'b0;
    for (int i = 0; i < 256; i++) tx_mem[i] = 8'(i);
    run_burst(256, 8'h00, -1, 0, -1, 0);
    check("t3_nrx", rx_q.size(), 256);
    check("t3_rx_first", rx_at(0), 8'h00);
    check("t3_rx_last", rx_at(255), 8'hFF);
    check("t3_nspdr", n_spdr_wr, 256);
    check("t3_done", n_done, 1);
    check("t3_err", err_at_done, 0);
    check("t3_busy", busy_gap, 0);

    // rx held 50 cycles on byte 0, tx gapped 30 cycles before byte 1
    tx_mem[0] = 8'h11; tx_mem[1] = 8'h22; tx_mem[2] = 8'h33;
    run_burst(3, 8'h00, 1, 30, 0, 50);
    check("t4_hold", stall_hold, 50);
    check("t4_gap_ready", stall_ready, 30);
    check("t4_stable", rx_unstable, 0);
    check("t4_no_access", stall_acc, 0);
    check("t4_rx0", rx_at(0), 8'h11);
    check("t4_rx2", rx_at(2), 8'h33);
    check("t4_nspdr", n_spdr_wr, 3);

    // SPIF never sets: 16 polls then timeout
    sl_stuck = 1'b1;
    tx_mem[0] = 8'h5A;
    run_burst(1, 8'h00, -1, 0, -1, 0);
    check("t5_polls", n_spsr_rd, 16);
    check("t5_nwr", wr_log.size(), 2);
    check("t5_err", err_at_done, 1);
    check("t5_done", n_done, 1);
    check("t5_nrx", rx_q.size(), 0);
    @(negedge CLK);
    check("t5_err_sticky", err, 1);

    // A new start clears err
    sl_stuck = 1'b0;
    tx_mem[0] = 8'h77;
    run_burst(1, 8'h00, -1, 0, -1, 0);
    check("t5_err_cleared", err_first, 0);
    check("t5_rx_after", rx_at(0), 8'h77);

    // Reset asserted while polling
    sl_stuck = 1'b1;
    @(negedge CLK);
    start = 1'b1; cfg_spcr = 8'h00; len = 8'd1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 20 && !tx_ready; i++) @(negedge CLK);
    tx_valid = 1'b1; tx_data = 8'h99;
    @(negedge CLK);
    tx_valid = 1'b0;
    for (int i = 0; i < 20 && !(RE && ADDRD == 8'h03); i++) @(negedge CLK);
    @(negedge CLK);
    check("t6_in_poll", {RE, ADDRD}, {1'b1, 8'h03});
    RESETn = 1'b0;
    #1;
    check("t6_bus_idle", {psel, penable, WE, RE, ADDRD, DATABO}, {4'b0100, 16'h0000});
    check("t6_status", {busy, rx_valid}, 2'b00);
    @(negedge CLK);
    RESETn = 1'b1;
    sl_stuck = 1'b0;
    tx_mem[0] = 8'h3C;
    run_burst(1, 8'h00, -1, 0, -1, 0);
    check("t6_spcr", wr_at(0), 16'h0240);
    check("t6_rx", rx_at(0), 8'h3C);
    check("t6_err", err_at_done, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_burst_ctrl.md
Name: spi_burst_ctrl

Overview:
Register-bus sequencer that sits directly upstream of the SPI master and drives its SFR port (psel/penable/WE/RE/ADDRD/data). It converts a host-side byte stream into a programmed burst of SPI transfers. For each burst it writes SPCR once, then loops per byte: write SPDR, poll SPSR.SPIF, read the received byte, clear SPIF, and emit the byte on an output stream. It isolates host logic (pipe/trigger glue) from the SFR access protocol.

Parameters:
SPCR_ADDR, 8'h02, SFR address of the SPI control register
SPSR_ADDR, 8'h03, SFR address of the SPI status register
SPDR_ADDR, 8'h04, SFR address of the SPI data register
TIMEOUT_CYCLES, 4096, max poll cycles waiting for SPIF per byte (12-bit counter)

Ports:
CLK  in  1  system clock
RESETn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a burst when idle
cfg_spcr  in  8  SPCR value for the burst; bit 6 (SPE) forced to 1 on write
len  in  8  byte count; 0 means 256
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at burst end (normal or timeout)
err  out  1  sticky timeout flag; cleared by an accepted start
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  byte accepted when tx_valid & tx_ready
rx_data  out  8  received byte
rx_valid  out  1  rx_data valid; held until accepted
rx_ready  in  1  consumer accepts when rx_valid & rx_ready
psel  out  1  SFR select to SPI master, active 1
penable  out  1  SFR strobe to SPI master, active 0
WE  out  1  SFR write
RE  out  1  SFR read
ADDRD  out  8  SFR address
DATABO  out  8  write data to SPI master DATABI
DATABI  in  8  read data from SPI master DATAB (combinational on ADDRD)

Behaviour:
- Reset, async on RESETn low: all outputs 0 except penable=1. The FSM goes to IDLE, counters and err are cleared, and rx_data is 8'h00. Reset mid-burst aborts the burst immediately, with no further SFR access.
- Bus idle value: psel=0, penable=1, WE=0, RE=0, ADDRD=8'h00, DATABO=8'h00.
- SFR write: one cycle with psel=1, penable=0, WE=1, ADDRD, DATABO. SFR read: one cycle with psel=1, penable=0, RE=1, ADDRD; DATABI is sampled at the end of that same cycle.
- All bus outputs are registered.
- FSM states:
  - IDLE: on start, latch cfg and remaining = (len==0 ? 256 : len) in a 9-bit counter, clear err, and go to WR_SPCR. start is ignored in all other states.
  - WR_SPCR: write SPCR = cfg_spcr | 8'h40, then go to GET_TX.
  - GET_TX: tx_ready=1 (only here). On accept, latch the byte and go to WR_SPDR.
  - WR_SPDR: write SPDR = latched byte. Load timeout_cnt = TIMEOUT_CYCLES-1 and go to POLL.
  - POLL: read SPSR every cycle.
    - If sampled bit0=1, go to RD_SPDR.
    - Otherwise, if timeout_cnt==0, set err, pulse done, and go to IDLE.
    - Otherwise decrement timeout_cnt.
  - RD_SPDR: read SPDR, capture DATABI into rx_data, and go to CLR_SPIF.
  - CLR_SPIF: write SPSR = 8'h01 (clears SPIF), then go to PUSH_RX.
  - PUSH_RX: rx_valid=1. On rx_ready, decrement remaining. If remaining was 1, pulse done and go to IDLE; otherwise go to GET_TX.
- Back-pressure: tx starvation stalls in GET_TX and rx stall holds in PUSH_RX, both indefinitely; there is no timeout in these states. SCK is idle during stalls.
- busy=1 in every state except IDLE. done and busy are never both high after the done cycle.
- Latency: start to SPCR write is 1 cycle. tx accept to SPDR write is 1 cycle. SPIF sampled high to rx_valid is 3 cycles.
- rx_valid and tx_ready are never high in the same cycle.
- A zero-length burst does not exist: len=0 means 256 transfers.

Test Plan:
- start, cfg_spcr=8'h53, len=1, tx 8'hA5, slave loopback (MISO=MOSI). Required: SFR writes in order SPCR=8'h53, SPDR=8'hA5, SPSR=8'h01; rx_data=8'hA5; exactly one done pulse; err=0.
- len=4, tx bytes 01,02,03,04, slave returns inverted bytes. Required: rx sequence FE,FD,FC,FB; 4 SPDR writes; 4 SPSR clears; busy high throughout.
- len=0 burst with incrementing tx bytes. Required: exactly 256 rx bytes; done on the 256th rx accept; the remaining counter wraps without error.
- Hold rx_ready=0 for 50 cycles after the first byte. Required: rx_valid stays high and rx_data is stable; no SPDR write until accept. Likewise, gap tx_valid for 30 cycles: tx_ready stays high and no SFR access occurs.
- Slave model with SPE stuck 0 (SPIF never sets), TIMEOUT_CYCLES=16. Required: 16 SPSR reads, then err=1 and done pulse; a new start clears err.
- Assert RESETn low while in POLL. Required: bus returns to idle value in the same cycle; busy=0 and rx_valid=0; start after release runs a clean burst.
